mul_int: RTL and testbench
==========================

// Module: mul_int
// PURPOSE
//  Iterative shift-add integer multiplier; the multiply counterpart of the
//  iterative divider in the ALU datapath. Produces the full 2*DSZ-bit product
//  of two DSZ-bit operands, signed or unsigned, one partial product per cycle.
//  Sits beside the divider behind the same start/busy style interface and is
//  driven by the core's M*, UM* and */ style opcodes.
// PARAMETERS
//  DSZ  32  operand width in bits; product is 2*DSZ bits (DSZ >= 4)
// PORTS
//  clk    in   1      clock; all state changes on posedge
//  rst    in   1      reset; synchronous, active-high
//  start  in   1      begin multiply; sampled only when busy=0
//  sgn    in   1      1 = operands two's-complement signed, 0 = unsigned
//  x      in   DSZ    multiplicand, sampled with start
//  y      in   DSZ    multiplier, sampled with start
//  busy   out  1      calculation in progress
//  done   out  1      one-cycle pulse: p_hi/p_lo valid from this cycle
//  p_hi   out  DSZ    product upper half
//  p_lo   out  DSZ    product lower half
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, p_hi=0, p_lo=0, counter=0.
//   rst has priority over everything, including mid-operation; an aborted
//   multiply produces no done pulse.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  IDLE: start=1 at edge E0 -> latch mc=|x|, mp=|y| (magnitudes only when
//   sgn=1, else raw), neg = sgn & (x[DSZ-1]^y[DSZ-1]); acc(DSZ+1 bits)=0,
//   counter=0, busy<=1, go RUN. p_hi/p_lo keep the previous result until FIX.
//  RUN: each cycle: if mp[0], acc += mc; then {acc,mp} >>= 1 (logical; the
//   acc carry bit shifts into the DSZ-bit acc). counter++. After DSZ
//   iterations (edge E0+DSZ) go FIX.
//  FIX (edge E0+DSZ+1): {p_hi,p_lo} <= neg ? -{acc,mp} : {acc,mp} (2*DSZ-bit
//   two's complement); busy<=0; done<=1 for exactly this one cycle; go IDLE.
//  Latency: done high in the cycle after edge E0+DSZ+1, i.e. DSZ+1 cycles
//   after start sampled. Throughput: one multiply per DSZ+2 cycles.
//   Back-to-back: start may be asserted in the done cycle; accepted.
//  start while busy=1: ignored, operands not re-latched, no error.
//  Width rules: |x| of most-negative value = 2^(DSZ-1) fits DSZ unsigned
//   bits; the accumulator is DSZ+1 bits so the add never loses carry.
//   The product always fits 2*DSZ bits; no overflow flag.
//  Zero operands: no early exit; always the full DSZ iterations.
//  sgn=0: neg=0, operands used raw.
// TESTING (DSZ=32)
//  unsigned: x=FFFFFFFF y=FFFFFFFF sgn=0 -> p_hi=FFFFFFFE p_lo=00000001,
//   done exactly 33 cycles after start
//  signed mixed: x=FFFFFFFD(-3) y=00000007 sgn=1 -> p_hi=FFFFFFFF
//   p_lo=FFFFFFEB(-21); same operands sgn=0 -> p_hi=00000006 p_lo=FFFFFFEB
//  signed extreme: x=y=80000000 sgn=1 -> p_hi=40000000 p_lo=00000000
//  zero/hold: x=0 y=12345678 -> product 0; start pulsed again mid-RUN with
//   new operands -> ignored, first result correct, busy never drops early
//  reset mid-op: rst at iteration 10 -> busy=0, done never pulses, p=0;
//   next start x=6 y=7 -> p_lo=0000002A
//  back-to-back + random: start in each done cycle, 1000 random x/y/sgn vs
//   reference model -> all products match, one done per accepted start

Source files
------------

// File: rtl/mul_int.sv
`default_nettype none
// ============================================================================
//  Module      : mul_int
//  Description : Iterative shift-add integer multiplier. Produces the full
//                2*DSZ-bit product of two DSZ-bit operands, signed or
//                unsigned, retiring one partial product per clock behind a
//                start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_int #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic           done,
    output logic [DSZ-1:0] p_hi,
    output logic [DSZ-1:0] p_lo
);

    // Counter wide enough to hold DSZ-1 with headroom.
    localparam int c_CNT_W = $clog2(DSZ) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic [DSZ-1:0]   r_p_hi,  w_p_hi_nxt;
    logic [DSZ-1:0]   r_p_lo,  w_p_lo_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DSZ-1:0]   r_mc,    w_mc_nxt;
    logic [DSZ-1:0]   r_mp,    w_mp_nxt;
    logic [DSZ:0]     r_acc,   w_acc_nxt;
    logic             r_neg,   w_neg_nxt;

    logic [DSZ:0]     w_sum;
    logic [2*DSZ-1:0] w_prod;
    logic [2*DSZ-1:0] w_prod_fix;
    logic [DSZ-1:0]   w_x_mag;
    logic [DSZ-1:0]   w_y_mag;

    // Datapath helpers and next-state logic for the IDLE/RUN/FIX sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_cnt_nxt   = r_cnt;
        w_mc_nxt    = r_mc;
        w_mp_nxt    = r_mp;
        w_acc_nxt   = r_acc;
        w_neg_nxt   = r_neg;

        // Magnitude of the most-negative value wraps to 2^(DSZ-1), which is
        // still correct when read as unsigned.
        w_x_mag = (sgn && x[DSZ-1]) ? (-x) : x;
        w_y_mag = (sgn && y[DSZ-1]) ? (-y) : y;

        // Accumulator carries one extra bit so the add never drops a carry.
        w_sum = r_mp[0] ? (r_acc + {1'b0, r_mc}) : r_acc;

        w_prod     = {r_acc[DSZ-1:0], r_mp};
        w_prod_fix = r_neg ? (-w_prod) : w_prod;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mc_nxt    = w_x_mag;
                    w_mp_nxt    = w_y_mag;
                    w_neg_nxt   = sgn & (x[DSZ-1] ^ y[DSZ-1]);
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Add-then-shift: the low product bit retires into mp's top.
                w_acc_nxt = {1'b0, w_sum[DSZ:1]};
                w_mp_nxt  = {w_sum[0], r_mp[DSZ-1:1]};
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(DSZ - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_p_hi_nxt  = w_prod_fix[2*DSZ-1:DSZ];
                w_p_lo_nxt  = w_prod_fix[DSZ-1:0];
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any multiply in flight without a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_cnt   <= '0;
            r_mc    <= '0;
            r_mp    <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mc    <= w_mc_nxt;
            r_mp    <= w_mp_nxt;
            r_acc   <= w_acc_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p_hi = r_p_hi;
    assign p_lo = r_p_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_int
//  Description : Directed-vector and randomised self-checking bench for
//                mul_int at DSZ=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_int;

    localparam int DSZ = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           sgn;
    logic [DSZ-1:0] x;
    logic [DSZ-1:0] y;
    logic           busy;
    logic           done;
    logic [DSZ-1:0] p_hi;
    logic [DSZ-1:0] p_lo;

    int n_cmp;
    int n_fail;
    int n_done;
    int n_accepted;

    typedef struct {
        logic [31:0] vx;
        logic [31:0] vy;
        logic        vs;
        logic [63:0] vp;
    } vec_t;

    vec_t vecs[10];

    mul_int #(.DSZ(DSZ)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .p_hi  (p_hi),
        .p_lo  (p_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every done pulse seen on the sampling edge.
    always @(negedge clk) begin
        if (done) n_done = n_done + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // done is high, so a following call starts in the done cycle.
    task automatic do_mul(input logic [31:0] ax, input logic [31:0] ay, input logic as,
                          output logic [63:0] prod, output int lat);
        start = 1'b1;
        x     = ax;
        y     = ay;
        sgn   = as;
        @(posedge clk);
        n_accepted = n_accepted + 1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat = lat + 1;
        end
        if (!done) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
        prod = {p_hi, p_lo};
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] ax, input logic [31:0] ay, input logic as);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = as ? {{32{ax[31]}}, ax} : {32'd0, ax};
        ey = as ? {{32{ay[31]}}, ay} : {32'd0, ay};
        return ex * ey;
    endfunction

    initial begin
        logic [63:0] prod;
        int          lat;
        int          snap;
        logic        busy_low;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        n_cmp      = 0;
        n_fail     = 0;
        n_done     = 0;
        n_accepted = 0;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{32'hFFFFFFFD, 32'h00000007, 1'b0, 64'h00000006_FFFFFFEB};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        vecs[6] = '{32'h12345678, 32'h00000000, 1'b1, 64'h00000000_00000000};
        vecs[7] = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
        vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
        vecs[9] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFE};

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_p", {p_hi, p_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, issued back-to-back.
        for (int i = 0; i < 10; i++) begin
            do_mul(vecs[i].vx, vecs[i].vy, vecs[i].vs, prod, lat);
            check($sformatf("vec%0d_p", i), prod, vecs[i].vp);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(DSZ + 1));
        end
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Zero operand with a second start mid-RUN that must be ignored.
        start = 1'b1; x = 32'h0; y = 32'h12345678; sgn = 1'b0;
        @(posedge clk);
        n_accepted = n_accepted + 1;
        @(negedge clk);
        start = 1'b0;
        check("hold_prev_p", {p_hi, p_lo}, 64'hFFFFFFFF_FFFFFFFE);
        busy_low = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (!busy) busy_low = 1'b1;
        end
        start = 1'b1; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; sgn = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low = 1'b1;
            @(negedge clk);
            lat = lat + 1;
        end
        check("hold_busy_early_drop", {63'd0, busy_low}, 64'd0);
        check("hold_done_seen", {63'd0, done}, 64'd1);
        check("hold_p", {p_hi, p_lo}, 64'd0);
        @(negedge clk);

        // Reset in the middle of a multiply.
        start = 1'b1; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        snap = n_done;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_p", {p_hi, p_lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 64'(n_done), 64'(snap));
        do_mul(32'd6, 32'd7, 1'b0, prod, lat);
        check("after_rst_p", prod, 64'h00000000_0000002A);

        // Random operands, each start issued in the previous done cycle.
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 50 == 0) rx = 32'h80000000;
            do_mul(rx, ry, rs, prod, lat);
            check($sformatf("rand%0d", i), prod, ref_mul(rx, ry, rs));
        end
        @(negedge clk);
        check("done_count", 64'(n_done), 64'(n_accepted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
